systolic_mac_array: RTL and testbench

- DIM x DIM grid of signed multiply-accumulate cells. It is the parametrised successor to the single tpumac cell.
- A operands enter at column 0 and flow right, one per row. B operands enter at row 0 and flow down, one per column. Each cell accumulates A*B into its own C register.
- A row-select port preloads or reads back one row of C registers. Optional saturating arithmetic and a sticky overflow flag are included.
- Sits between the operand skew buffers and the result memory in the matrix-multiply datapath.

---
 rtl/systolic_mac_array.sv | 158 +++++++++++++++
 tb/tb_systolic_mac_array.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// systolic_mac_array: DIM x DIM grid of signed multiply-accumulate cells.
// A operands stream right along each row, B operands stream down each column,
// and every cell accumulates the product of what it sees into its own C
// register. One row of C can be preloaded from Cin or read out on Cout.
module systolic_mac_array #(
  parameter int DIM      = 4,
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic [$clog2(DIM)-1:0]    Crow,
  input  logic [DIM*BITS_AB-1:0]    A,
  input  logic [DIM*BITS_AB-1:0]    B,
  input  logic [DIM*BITS_C-1:0]     Cin,
  output logic [DIM*BITS_C-1:0]     Cout,
  output logic                      ovf
);

  localparam int CROW_W = $clog2(DIM);
  localparam int PW     = 2 * BITS_AB;
  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  // Unpacked views of the packed operand / preload buses.
  logic [BITS_AB-1:0] a_edge  [DIM];
  logic [BITS_AB-1:0] b_edge  [DIM];
  logic [BITS_C-1:0]  cin_col [DIM];
  logic [DIM-1:0]     row_sel;

  // Pipeline taps between neighbouring cells. The last column never forwards
  // A and the last row never forwards B, so those registers are not built.
  logic [BITS_AB-1:0] a_arr [DIM][DIM-1];
  logic [BITS_AB-1:0] b_arr [DIM-1][DIM];
  logic [BITS_C-1:0]  c_arr [DIM][DIM];
  logic [DIM*DIM-1:0] ovf_hit;

  logic ovf_q, ovf_d;

  genvar gi, gr, gc;

  generate
    for (gi = 0; gi < DIM; gi++) begin : g_port
      assign a_edge[gi]  = A[gi*BITS_AB +: BITS_AB];
      assign b_edge[gi]  = B[gi*BITS_AB +: BITS_AB];
      assign cin_col[gi] = Cin[gi*BITS_C +: BITS_C];
      // A Crow value with no matching row selects nothing.
      assign row_sel[gi] = (Crow == CROW_W'(gi));
    end

    for (gr = 0; gr < DIM; gr++) begin : g_row
      for (gc = 0; gc < DIM; gc++) begin : g_col
        logic [BITS_AB-1:0]      a_in, b_in;
        logic signed [PW-1:0]    prod;
        logic signed [BITS_C:0]  sum;
        logic                    sum_ovf;
        logic                    acc_ovf;
        logic [BITS_C-1:0]       c_q, c_d;

        if (gc == 0) begin : g_a_src
          assign a_in = a_edge[gr];
        end else begin : g_a_src
          assign a_in = a_arr[gr][gc-1];
        end

        if (gr == 0) begin : g_b_src
          assign b_in = b_edge[gc];
        end else begin : g_b_src
          assign b_in = b_arr[gr-1][gc];
        end

        // Full-width signed product, then one guard bit above the accumulator
        // so overflow is visible as a mismatch of the top two sum bits.
        assign prod = $signed({{BITS_AB{a_in[BITS_AB-1]}}, a_in}) *
                      $signed({{BITS_AB{b_in[BITS_AB-1]}}, b_in});
        assign sum = $signed({c_q[BITS_C-1], c_q}) +
                     $signed({{(BITS_C+1-PW){prod[PW-1]}}, prod});
        assign sum_ovf = sum[BITS_C] ^ sum[BITS_C-1];

        if (gc < DIM-1) begin : g_a_reg
          logic [BITS_AB-1:0] a_q, a_d;
          // A operand advances one column per enabled edge.
          always_comb a_d = en ? a_in : a_q;
          // A pipeline register.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) a_q <= '0;
            else     a_q <= a_d;
          end
          assign a_arr[gr][gc] = a_q;
        end

        if (gr < DIM-1) begin : g_b_reg
          logic [BITS_AB-1:0] b_q, b_d;
          // B operand advances one row per enabled edge.
          always_comb b_d = en ? b_in : b_q;
          // B pipeline register.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) b_q <= '0;
            else     b_q <= b_d;
          end
          assign b_arr[gr][gc] = b_q;
        end

        // Accumulator next value: preload on a selected row, else accumulate
        // with wrap or clamp; only a real accumulate may report overflow.
        always_comb begin
          c_d     = c_q;
          acc_ovf = 1'b0;
          if (en) begin
            if (WrEn && row_sel[gr]) begin
              c_d = cin_col[gc];
            end else begin
              acc_ovf = sum_ovf;
              if ((SATURATE != 0) && sum_ovf) c_d = sum[BITS_C] ? C_MIN : C_MAX;
              else                            c_d = sum[BITS_C-1:0];
            end
          end
        end

        // Accumulator register.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) c_q <= '0;
          else     c_q <= c_d;
        end

        assign c_arr[gr][gc]       = c_q;
        assign ovf_hit[gr*DIM+gc]  = acc_ovf;
      end
    end
  endgenerate

  // Sticky overflow: set by any cell overflowing, cleared only by reset.
  always_comb ovf_d = ovf_q | (|ovf_hit);

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

  // Readout mux: the row addressed by Crow, or zero when no row matches.
  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++) begin
      if (row_sel[r]) begin
        for (int c = 0; c < DIM; c++) begin
          Cout[c*BITS_C +: BITS_C] = c_arr[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Testbench for systolic_mac_array: a wrapping and a saturating instance
// share the same stimulus and are checked against a timeline model that
// tracks which sampled operands meet in each cell at each enabled edge.
`timescale 1ns/1ps
module tb_systolic_mac_array;

  localparam int N = 4;

  logic        clk, rst, en, WrEn;
  logic [1:0]  Crow;
  logic [31:0] A, B;
  logic [63:0] Cin;
  logic [63:0] cout_w, cout_s;
  logic        ovf_w, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          mc [N][N];   // wrapping accumulators
  int          ms [N][N];   // saturating accumulators
  bit          movf_w, movf_s;
  logic [31:0] hist_a [$];
  logic [31:0] hist_b [$];

  systolic_mac_array #(.DIM(4), .BITS_AB(8), .BITS_C(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .Crow(Crow),
    .A(A), .B(B), .Cin(Cin), .Cout(cout_w), .ovf(ovf_w));

  systolic_mac_array #(.DIM(4), .BITS_AB(8), .BITS_C(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .Crow(Crow),
    .A(A), .B(B), .Cin(Cin), .Cout(cout_s), .ovf(ovf_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mc[r][c] = 0;
        ms[r][c] = 0;
      end
    movf_w = 0;
    movf_s = 0;
    hist_a.delete();
    hist_b.delete();
  endtask

  // Cell (r,c) at enabled edge t multiplies A sampled at edge t-c by
  // B sampled at edge t-r (zero before the first sample).
  task automatic model_edge();
    int t, p, s;
    logic [31:0] va, vb;
    logic signed [7:0]  av, bv;
    logic signed [15:0] cv, wv;
    if (!en) return;
    hist_a.push_back(A);
    hist_b.push_back(B);
    t = hist_a.size() - 1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        av = 0;
        bv = 0;
        if (t - c >= 0) begin va = hist_a[t-c]; av = va[r*8 +: 8]; end
        if (t - r >= 0) begin vb = hist_b[t-r]; bv = vb[c*8 +: 8]; end
        if (WrEn && int'(Crow) == r) begin
          cv = Cin[c*16 +: 16];
          mc[r][c] = int'(cv);
          ms[r][c] = int'(cv);
        end else begin
          p = int'(av) * int'(bv);
          s = mc[r][c] + p;
          if (s > 32767 || s < -32768) movf_w = 1;
          wv = s[15:0];
          mc[r][c] = int'(wv);
          s = ms[r][c] + p;
          if (s > 32767)       begin s = 32767;  movf_s = 1; end
          else if (s < -32768) begin s = -32768; movf_s = 1; end
          ms[r][c] = s;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input int r, output logic [63:0] w, output logic [63:0] s);
    Crow = 2'(r);
    #0.2;
    w = cout_w;
    s = cout_s;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [63:0] w, s;
    en = 1'b1; WrEn = 1'b1; Crow = 2'd1;
    Cin = 64'h1234_5678_9abc_def0; A = 32'h0102_0304; B = 32'h0506_0708;
    tick();
    en = 1'b0; A = 32'h7f7f_7f7f; B = 32'h8181_8181; Cin = 64'h1111_2222_3333_4444;
    @(negedge clk);
    #2 rst = 1'b1;
    read_row(1, w, s);
    n_checks++;
    if (w !== 64'd0 || s !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_async_row1: wrap=%h sat=%h required 0", w, s);
    end
    #0.8 rst = 1'b0;
    model_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < N; r++) begin
        read_row(r, w, s);
        n_checks++;
        if (w !== 64'd0 || s !== 64'd0) begin
          n_fail++;
          $display("FAIL reset_row%0d pass%0d: wrap=%h sat=%h required 0", r, pass, w, s);
        end
      end
      n_checks++;
      if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ovf pass%0d: wrap=%b sat=%b required 0", pass, ovf_w, ovf_s);
      end
      $display("reset pass %0d: rows checked zero", pass);
      if (pass == 0) repeat (3) tick();
    end
  endtask

  task automatic test_enable_hold();
    logic [63:0] w, s;
    en = 1'b0; WrEn = 1'b1; A = 32'h0808_0808; B = 32'h0808_0808;
    Cin = {4{16'h0005}};
    for (int k = 0; k < 5; k++) begin
      Crow = 2'(k);
      tick();
    end
    for (int r = 0; r < N; r++) begin
      read_row(r, w, s);
      n_checks++;
      if (w !== 64'd0 || s !== 64'd0) begin
        n_fail++;
        $display("FAIL enable_hold_row%0d: wrap=%h sat=%h required 0", r, w, s);
      end
      $display("enable_hold row %0d: %h", r, w);
    end
  endtask

  task automatic test_preload();
    logic [63:0] w, s, exp;
    en = 1'b1; WrEn = 1'b1; Crow = 2'd2;
    Cin = {16'd40, 16'd30, 16'd20, 16'd10}; A = 32'd0; B = 32'd0;
    tick();
    en = 1'b0; WrEn = 1'b0;
    for (int r = 0; r < N; r++) begin
      exp = (r == 2) ? {16'd40, 16'd30, 16'd20, 16'd10} : 64'd0;
      read_row(r, w, s);
      n_checks++;
      if (w !== exp || s !== exp) begin
        n_fail++;
        $display("FAIL preload_row%0d: wrap=%h sat=%h required %h", r, w, s, exp);
      end
      $display("preload row %0d: %h", r, w);
    end
  endtask

  task automatic test_matmul();
    logic [63:0] w, s, exp;
    int j;
    pulse_reset();
    en = 1'b1; WrEn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      A = '0;
      B = '0;
      for (int r = 0; r < N; r++) begin
        j = k - r;   // identity A: row r carries a 1 at term r
        if (j >= 0 && j < N && j == r) A[r*8 +: 8] = 8'd1;
      end
      for (int c = 0; c < N; c++) begin
        j = k - c;
        if (j >= 0 && j < N) B[c*8 +: 8] = 8'(4*j + c + 1);
      end
      tick();
    end
    A = '0; B = '0; en = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) exp[c*16 +: 16] = 16'(4*r + c + 1);
      read_row(r, w, s);
      n_checks++;
      if (w !== exp || s !== exp) begin
        n_fail++;
        $display("FAIL matmul_row%0d: wrap=%h sat=%h required %h", r, w, s, exp);
      end
      $display("matmul row %0d: %h", r, w);
    end
    n_checks++;
    if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
      n_fail++;
      $display("FAIL matmul_ovf: wrap=%b sat=%b required 0", ovf_w, ovf_s);
    end
  endtask

  task automatic test_signed_mac();
    logic [63:0] w, s;
    pulse_reset();
    en = 1'b1; WrEn = 1'b0;
    A = {24'd0, 8'hFD}; B = {24'd0, 8'd7};
    repeat (3) tick();
    en = 1'b0;
    read_row(0, w, s);
    n_checks++;
    if (w[15:0] !== 16'hFFC1 || s[15:0] !== 16'hFFC1) begin
      n_fail++;
      $display("FAIL signed_mac_c00: wrap=%h sat=%h required ffc1", w[15:0], s[15:0]);
    end
    $display("signed_mac cell(0,0): %h", w[15:0]);
    for (int r = 0; r < N; r++) begin
      read_row(r, w, s);
      for (int c = 0; c < N; c++) begin
        n_checks++;
        if (w[c*16 +: 16] !== 16'(mc[r][c]) || s[c*16 +: 16] !== 16'(ms[r][c])) begin
          n_fail++;
          $display("FAIL signed_mac_c%0d%0d: wrap=%h sat=%h required %h/%h",
                   r, c, w[c*16 +: 16], s[c*16 +: 16], 16'(mc[r][c]), 16'(ms[r][c]));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] w, s;
    pulse_reset();
    en = 1'b1; WrEn = 1'b1; Crow = 2'd0;
    Cin = {48'd0, 16'h7FFF}; A = 32'd0; B = 32'd0;
    tick();
    n_checks++;
    if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_after_load: wrap=%b sat=%b required 0", ovf_w, ovf_s);
    end
    WrEn = 1'b0; A = 32'd1; B = 32'd1;
    tick();
    read_row(0, w, s);
    n_checks++;
    if (w[15:0] !== 16'h8000 || ovf_w !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_wrap: c00=%h ovf=%b required 8000 ovf=1", w[15:0], ovf_w);
    end
    n_checks++;
    if (s[15:0] !== 16'h7FFF || ovf_s !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sat: c00=%h ovf=%b required 7fff ovf=1", s[15:0], ovf_s);
    end
    $display("overflow: wrap=%h sat=%h ovf=%b/%b", w[15:0], s[15:0], ovf_w, ovf_s);
    A = 32'd0; B = 32'd0;
    repeat (3) tick();
    n_checks++;
    if (ovf_w !== 1'b1 || ovf_s !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: wrap=%b sat=%b required 1", ovf_w, ovf_s);
    end
    pulse_reset();
    n_checks++;
    if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: wrap=%b sat=%b required 0", ovf_w, ovf_s);
    end
  endtask

  task automatic test_random();
    logic [63:0] w, s;
    int errs;
    pulse_reset();
    for (int it = 0; it < 300; it++) begin
      if (it % 75 == 74) pulse_reset();
      en   = ($urandom_range(0, 4) != 0);
      WrEn = ($urandom_range(0, 5) == 0);
      Crow = 2'($urandom_range(0, 3));
      A    = $urandom;
      B    = $urandom;
      Cin  = {$urandom, $urandom};
      if (it >= 150) begin
        // small operands so accumulators spend time away from the rails
        for (int k = 0; k < N; k++) begin
          A[k*8 +: 8] = 8'($signed($urandom_range(0, 6)) - 3);
          B[k*8 +: 8] = 8'($signed($urandom_range(0, 6)) - 3);
        end
        Cin = {4{16'($urandom_range(0, 200))}};
      end
      tick();
      errs = 0;
      for (int r = 0; r < N; r++) begin
        read_row(r, w, s);
        for (int c = 0; c < N; c++) begin
          n_checks++;
          if (w[c*16 +: 16] !== 16'(mc[r][c]) || s[c*16 +: 16] !== 16'(ms[r][c])) begin
            n_fail++;
            errs++;
            $display("FAIL random_it%0d_c%0d%0d: wrap=%h sat=%h required %h/%h",
                     it, r, c, w[c*16 +: 16], s[c*16 +: 16], 16'(mc[r][c]), 16'(ms[r][c]));
          end
        end
      end
      n_checks++;
      if (ovf_w !== movf_w || ovf_s !== movf_s) begin
        n_fail++;
        errs++;
        $display("FAIL random_it%0d_ovf: wrap=%b sat=%b required %b/%b",
                 it, ovf_w, ovf_s, movf_w, movf_s);
      end
      $display("random it %0d: en=%b wr=%b crow=%0d A=%h B=%h errs=%0d",
               it, en, WrEn, Crow, A, B, errs);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; WrEn = 1'b0; Crow = 2'd0;
    A = '0; B = '0; Cin = '0;
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_enable_hold();
    test_preload();
    test_matmul();
    test_signed_mac();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
